// File: rtl/pipe_mult_hs_pkg.sv
// Shared helpers for the pipelined multiplier and other fixed-point datapath blocks.
// sat_round works on a wide container so one definition serves any operand/result widths.
package pipe_mult_hs_pkg;

  // Wide enough for any supported product plus sign/rounding headroom.
  localparam int unsigned MAX_W = 128;

  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] res;
  } sat_round_t;

  function automatic int unsigned clog2(input int unsigned x);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < x) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

  function automatic int unsigned latency(input int unsigned stages);
    return stages + 1;
  endfunction

  // p must already be sign- or zero-extended to MAX_W, which leaves the rounding add
  // plenty of headroom. Rounds half up, then clamps to an out_w-bit result.
  function automatic sat_round_t sat_round(input logic [MAX_W-1:0] p,
                                           input logic             is_signed,
                                           input int unsigned      shift,
                                           input int unsigned      out_w);
    logic [MAX_W-1:0] one, sum, q, max_s, min_s, max_u;
    sat_round_t       r;
    one = MAX_W'(1);
    sum = p;
    if (shift > 0) sum = p + (one << (shift - 1));
    if (is_signed) q = $signed(sum) >>> shift;
    else           q = sum >> shift;
    max_s = (one << (out_w - 1)) - one;
    min_s = ~max_s;
    max_u = (one << out_w) - one;
    r.sat = 1'b0;
    r.res = q;
    if (is_signed) begin
      if ($signed(q) > $signed(max_s)) begin
        r.sat = 1'b1;
        r.res = max_s;
      end else if ($signed(q) < $signed(min_s)) begin
        r.sat = 1'b1;
        r.res = min_s;
      end
    end else if (q > max_u) begin
      r.sat = 1'b1;
      r.res = max_u;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_mult_hs_stage.sv
// One pipeline slot of the multiplier: a valid bit plus a data register, both frozen while
// en is low. The data register can optionally be reset (used for the visible output slot).
module pipe_stage_hs #(
  parameter int unsigned W          = 8,
  parameter bit          RESET_DATA = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (en) begin
      valid_q <= src_valid;
    end
  end

  // Bubbles do not load data, so a slot keeps its last payload until real data arrives.
  if (RESET_DATA) begin : g_rst_data
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else if (en && src_valid) begin
        data_q <= src_data;
      end
    end
  end else begin : g_keep_data
    always_ff @(posedge clk) begin
      if (en && src_valid) begin
        data_q <= src_data;
      end
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_mult_hs.sv
// Fully pipelined A_W x B_W multiplier with valid/ready on both sides, per-beat signed mode
// and a round/shift/saturate output stage. Latency is STAGES+1 slots with a global stall.
module pipe_mult_hs
  import pipe_mult_hs_pkg::*;
#(
  parameter int unsigned A_W    = 8,
  parameter int unsigned B_W    = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [A_W-1:0]                  in_a,
  input  logic [B_W-1:0]                  in_b,
  input  logic                            in_signed,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_W-1:0]                out_res,
  output logic                            out_sat,
  output logic [clog2(STAGES+2)-1:0]      inflight
);

  localparam int unsigned PROD_W = prod_width(A_W, B_W);
  localparam int unsigned LAT    = latency(STAGES);
  localparam int unsigned DW     = PROD_W + 1;
  localparam int unsigned CNT_W  = clog2(LAT + 1);

  logic                 en;
  logic                 accept;
  logic                 deliver;
  logic [LAT-1:0]       vld;
  logic [DW-1:0]        slot_data [STAGES];
  logic [OUT_W:0]       fin_data;

  logic                 op_signed;
  logic [A_W-1:0]       op_a;
  logic [B_W-1:0]       op_b;
  logic [PROD_W-1:0]    op_a_ext;
  logic [PROD_W-1:0]    op_b_ext;
  logic [PROD_W-1:0]    prod;

  logic [DW-1:0]        pre_fin;
  logic [MAX_W-1:0]     pre_fin_ext;
  sat_round_t           rounded;
  logic                 unused_rounded;

  logic [CNT_W-1:0]     inflight_q;
  logic [CNT_W-1:0]     inflight_d;

  // Whole pipe advances together; a full pipe can still accept while the head drains.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign deliver  = out_valid && out_ready;

  // Multiply sits in front of slot 1 so retiming can spread it over the following registers.
  assign {op_signed, op_a, op_b} = slot_data[0];
  assign op_a_ext = {{B_W{op_signed & op_a[A_W-1]}}, op_a};
  assign op_b_ext = {{A_W{op_signed & op_b[B_W-1]}}, op_b};
  assign prod     = op_a_ext * op_b_ext;

  if (STAGES == 1) begin : g_fin_direct
    assign pre_fin = {op_signed, prod};
  end else begin : g_fin_piped
    assign pre_fin = slot_data[STAGES-1];
  end

  assign pre_fin_ext = {{(MAX_W - PROD_W){pre_fin[DW-1] & pre_fin[PROD_W-1]}},
                        pre_fin[PROD_W-1:0]};
  assign rounded        = sat_round(pre_fin_ext, pre_fin[DW-1], SHIFT, OUT_W);
  assign unused_rounded = ^rounded.res[MAX_W-1:OUT_W];

  for (genvar i = 0; i < LAT; i++) begin : g_slot
    if (i == 0) begin : g_in
      pipe_stage_hs #(
        .W          (DW),
        .RESET_DATA (1'b0)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .src_valid (in_valid),
        .src_data  ({in_signed, in_a, in_b}),
        .valid     (vld[i]),
        .data      (slot_data[i])
      );
    end else if (i < STAGES) begin : g_mid
      pipe_stage_hs #(
        .W          (DW),
        .RESET_DATA (1'b0)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .src_valid (vld[i-1]),
        .src_data  ((i == 1) ? {op_signed, prod} : slot_data[i-1]),
        .valid     (vld[i]),
        .data      (slot_data[i])
      );
    end else begin : g_out
      pipe_stage_hs #(
        .W          (OUT_W + 1),
        .RESET_DATA (1'b1)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .src_valid (vld[i-1]),
        .src_data  ({rounded.sat, rounded.res[OUT_W-1:0]}),
        .valid     (vld[i]),
        .data      (fin_data)
      );
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_res   = fin_data[OUT_W-1:0];
  assign out_sat   = fin_data[OUT_W];

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, deliver})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign inflight = inflight_q;

endmodule

// File: doc/pipe_mult_hs.md
Name: pipe_mult_hs

Overview:
Parametrised, fully pipelined integer multiplier with valid/ready handshakes on both sides. Each operation carries its own signed/unsigned mode. An optional fixed-point output stage applies a right shift, rounds and saturates. This is the general-purpose multiply unit for datapaths that need backpressure, configurable latency and narrower outputs. With default parameters it gives the plain 8x8->16 three-cycle multiply.

Parameters:
A_W, 8, operand A width (>=2)
B_W, 8, operand B width (>=2)
STAGES, 2, product pipeline stages after the input register (>=1); total latency LAT = STAGES+1
OUT_W, 16, result width (1..A_W+B_W)
SHIFT, 0, right shift applied to the full product before output (0..A_W+B_W-1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
in_a  in  A_W  operand A
in_b  in  B_W  operand B
in_signed  in  1  1 = two's-complement operands; 0 = unsigned
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_res  out  OUT_W  shifted, rounded, saturated product
out_sat  out  1  this result was saturated
inflight  out  $clog2(LAT+1)  count of accepted operations not yet delivered

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all stage valid bits, out_valid, out_sat and inflight go to 0.
  - out_res goes to 0.
  - Data registers need not be reset.
- Pipeline: LAT register slots, each with its own valid bit.
  - Slot 0 is the input register (a, b, signed).
  - Slots 1..STAGES-1 carry the partial/full product plus signed flag.
  - The final slot drives out_*.
- Advance enable: en = !out_valid || out_ready. When en=1 every slot shifts forward one step. When en=0 all slots hold (global stall, no bubble collapse).
- in_ready = en, combinational. Accept = in_valid && in_ready. A non-accepted cycle inserts a bubble (valid=0) into slot 0 when en=1.
- Latency: a beat accepted at edge N gives out_valid=1 after edge N+LAT-1, provided there are no stalls. Each stall cycle adds one cycle. Results leave strictly in acceptance order.
- Throughput: one result per cycle while out_ready=1.
- Arithmetic:
  - Full product P is A_W+B_W bits.
  - Signed op: operands are sign-extended and the product is signed.
  - Unsigned op: operands are zero-extended.
- Output stage (computed in the last slot's input logic):
  - If SHIFT>0: Q = (P + 2^(SHIFT-1)) >> SHIFT. This is round-half-up, with an arithmetic shift for signed ops. The addition is carried out one bit wider so it cannot overflow.
  - If SHIFT=0: Q = P.
  - Saturate Q to OUT_W. The signed range is [-2^(OUT_W-1), 2^(OUT_W-1)-1]; the unsigned range is [0, 2^OUT_W-1].
  - out_sat=1 iff clamping occurred.
  - With defaults, out_sat is always 0 and out_res = P.
- inflight:
  - +1 on accept, -1 on out_valid && out_ready, unchanged when both happen in the same cycle.
  - Never exceeds LAT.
- Boundaries:
  - Simultaneous output handshake and new accept while full: allowed, same cycle.
  - out_valid && !out_ready: out_res and out_sat are held stable.
  - Reset mid-operation: all in-flight results are discarded. No out_valid appears after reset until a fresh accept has travelled LAT cycles.
  - in_signed is sampled per beat. A mixed signed/unsigned stream is legal.

Decomposition:
- Shared package holds:
  - function clog2
  - localparam derivation PROD_W = A_W+B_W, LAT = STAGES+1
  - the rounding/saturation function sat_round(P, is_signed), shared with other fixed-point blocks
- One natural sub-module: pipe_stage_hs (valid+data register with enable and async active-low reset, data width parameter), instantiated LAT times through a generate loop.
- The product register chain uses retiming-friendly registers (multiply before slot 1, registers after) so synthesis can balance the stages.

Test Plan:
- Defaults, unsigned 8'd255*8'd255, out_ready=1 -> out_res=16'd65025 (0xFE01) exactly 3 cycles after accept; out_sat=0; inflight 1,1,1,0.
- Defaults, signed 8'h80*8'h7F -> 16'hC080 (-16256); same operands unsigned the next cycle -> 16'd16256 (0x3F80), back-to-back, in order.
- Backpressure: stream 6 beats (1*1..6*6), out_ready=0 from the cycle the first result appears, for 5 cycles:
  - in_ready drops, out_res holds 1, inflight=3.
  - On release, 1,4,9,16,25,36 arrive on consecutive cycles with no loss or duplication.
- OUT_W=8, SHIFT=4:
  - unsigned 3*3 -> 1, sat=0.
  - unsigned 200*200 -> 255, sat=1.
  - signed -128*127 -> -128 (8'h80), sat=1.
  - signed -3*3 -> -1 (8'hFF), sat=0.
- Reset mid-flight: 2 beats accepted, rst_n low 1 cycle at cycle 1 -> out_valid=0 and inflight=0 immediately, no result for either beat; a new beat after reset -> result after LAT.
- Random soak, STAGES=4, random in_valid/out_ready/in_signed for 10k ops vs. a reference model -> zero mismatches; inflight<=5 always.
